// File: rtl/riscvvec_muldiv_iter_pkg.sv
// Shared definitions for the iterative multi-lane multiply/divide unit.
// Holds the function codes carried in muldivreq_msg_fn, the FSM state
// type and a small helper that the top and the lane datapath both use.
package riscvvec_muldiv_iter_pkg;

   localparam int FN_W = 3;

   localparam logic [FN_W-1:0] FN_MUL  = 3'd0;
   localparam logic [FN_W-1:0] FN_DIV  = 3'd1;
   localparam logic [FN_W-1:0] FN_DIVU = 3'd2;
   localparam logic [FN_W-1:0] FN_REM  = 3'd3;
   localparam logic [FN_W-1:0] FN_REMU = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Signed divide/remainder work on magnitudes and fix the sign at the end.
   function automatic logic is_signed_div(input logic [FN_W-1:0] fn);
      return (fn == FN_DIV) || (fn == FN_REM);
   endfunction

endpackage

// File: rtl/riscvvec_muldiv_lane.sv
// One lane of the iterative multiply/divide datapath.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   load          capture operands (magnitudes and signs) for a new request
//   step          perform one shift-add or one restoring-divide step
//   fn_req        function code of the incoming request (used on load only)
//   fn            function code latched by the top for the running request
//   active        lane mask bit latched by the top
//   a_in, b_in    raw lane operands (used on load only)
//   result        final lane result; stable once stepping stops
module riscvvec_muldiv_lane
   import riscvvec_muldiv_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic [FN_W-1:0]   fn_req,
   input  logic [FN_W-1:0]   fn,
   input  logic              active,
   input  logic [WIDTH-1:0]  a_in,
   input  logic [WIDTH-1:0]  b_in,
   output logic [WIDTH-1:0]  result
);

   // op_a: multiplicand (MUL) or dividend shifting into quotient (DIV)
   // op_b: multiplier (MUL) or divisor (DIV)
   // acc:  product (MUL) or partial remainder (DIV)
   logic [WIDTH-1:0] op_a, op_b, acc;
   logic             sign_a, sign_b, b_zero;

   logic             sgn_a_in, sgn_b_in;
   logic [WIDTH:0]   shifted, diff;
   logic             q_bit;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      sgn_a_in = is_signed_div(fn_req) & a_in[WIDTH-1];
      sgn_b_in = is_signed_div(fn_req) & b_in[WIDTH-1];
      shifted  = {acc, op_a[WIDTH-1]};
      diff     = shifted - {1'b0, op_b};
      // The partial remainder stays below the divisor, so bit WIDTH of diff
      // is set exactly when the trial subtraction borrowed.
      q_bit    = ~diff[WIDTH];
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_a   <= '0;
         op_b   <= '0;
         acc    <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         b_zero <= 1'b0;
      end else if (load) begin
         op_a   <= sgn_a_in ? -a_in : a_in;
         op_b   <= sgn_b_in ? -b_in : b_in;
         acc    <= '0;
         sign_a <= sgn_a_in;
         sign_b <= sgn_b_in;
         b_zero <= (b_in == '0);
      end else if (step) begin
         if (fn == FN_MUL) begin
            acc  <= acc + (op_b[0] ? op_a : '0);
            op_a <= op_a << 1;
            op_b <= op_b >> 1;
         end else begin
            acc  <= q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            op_a <= {op_a[WIDTH-2:0], q_bit};
         end
      end
   end

   // Sign fix-up and corner cases. MIN_INT / -1 needs no override: the
   // magnitude quotient is 2^(WIDTH-1), whose negation wraps back to MIN_INT,
   // and the remainder is 0. A zero divisor leaves quotient all-ones and
   // remainder |a| naturally; only the signed quotient's sign fix must be bypassed.
   always_comb begin
      result = '0;
      if (active) begin
         case (fn)
            FN_MUL:  result = acc;
            FN_DIV:  result = b_zero ? '1 : ((sign_a ^ sign_b) ? -op_a : op_a);
            FN_DIVU: result = b_zero ? '1 : op_a;
            FN_REM:  result = sign_a ? -acc : acc;
            FN_REMU: result = acc;
            default: result = '0;
         endcase
      end
   end

endmodule

// File: rtl/riscvvec_muldiv_iter.sv
// Multi-lane iterative integer multiply/divide unit (val/rdy request/response).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   muldivreq_msg_fn        0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU, 5-7 reserved
//   muldivreq_msg_mask      per-lane active mask
//   muldivreq_msg_a/b       lane operands, lane i at [i*WIDTH +: WIDTH]
//   muldivreq_val/rdy       request handshake
//   muldivresp_msg_result   lane results, same packing
//   muldivresp_val/rdy      response handshake
// Accept in IDLE, WIDTH step cycles in CALC, hold result in DONE until taken.
module riscvvec_muldiv_iter
   import riscvvec_muldiv_iter_pkg::*;
#(
   parameter int NLANES = 4,
   parameter int WIDTH  = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [FN_W-1:0]          muldivreq_msg_fn,
   input  logic [NLANES-1:0]        muldivreq_msg_mask,
   input  logic [NLANES*WIDTH-1:0]  muldivreq_msg_a,
   input  logic [NLANES*WIDTH-1:0]  muldivreq_msg_b,
   input  logic                     muldivreq_val,
   output logic                     muldivreq_rdy,
   output logic [NLANES*WIDTH-1:0]  muldivresp_msg_result,
   output logic                     muldivresp_val,
   input  logic                     muldivresp_rdy
);

   localparam int CNT_W = $clog2(WIDTH);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [FN_W-1:0]   fn_q;
   logic [NLANES-1:0] mask_q;
   logic              load, step;

   always_comb begin
      state_d        = state_q;
      muldivreq_rdy  = 1'b0;
      muldivresp_val = 1'b0;
      load           = 1'b0;
      step           = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Not ready while reset is held, so nothing is accepted before release.
            muldivreq_rdy = ~reset;
            load          = muldivreq_val & ~reset;
            if (load) state_d = ST_CALC;
         end
         ST_CALC: begin
            step = 1'b1;
            if (cnt_q == '0) state_d = ST_DONE;
         end
         ST_DONE: begin
            muldivresp_val = 1'b1;
            if (muldivresp_rdy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: all control and lane registers are reset; there are no storage
   // arrays here, so clearing everything costs nothing and keeps result=0 out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         fn_q    <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            cnt_q  <= CNT_W'(WIDTH - 1);
            fn_q   <= muldivreq_msg_fn;
            mask_q <= muldivreq_msg_mask;
         end else if (step) begin
            cnt_q  <= cnt_q - 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NLANES; i++) begin : g_lane
      riscvvec_muldiv_lane #(.WIDTH(WIDTH)) u_lane (
         .clk    (clk),
         .reset  (reset),
         .load   (load),
         .step   (step),
         .fn_req (muldivreq_msg_fn),
         .fn     (fn_q),
         .active (mask_q[i]),
         .a_in   (muldivreq_msg_a[i*WIDTH +: WIDTH]),
         .b_in   (muldivreq_msg_b[i*WIDTH +: WIDTH]),
         .result (muldivresp_msg_result[i*WIDTH +: WIDTH])
      );
   end

endmodule

// File: tb/tb_riscvvec_muldiv_iter.sv
// Self-checking bench for riscvvec_muldiv_iter (NLANES=4, WIDTH=32):
// directed cases plus randomized requests against an arithmetic reference model.
module tb_riscvvec_muldiv_iter;

   localparam int NLANES = 4;
   localparam int WIDTH  = 32;
   localparam int VW     = NLANES * WIDTH;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    req_fn;
   logic [3:0]    req_mask;
   logic [VW-1:0] req_a, req_b;
   logic          req_val, req_rdy;
   logic [VW-1:0] resp_result;
   logic          resp_val, resp_rdy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   riscvvec_muldiv_iter #(.NLANES(NLANES), .WIDTH(WIDTH)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .muldivreq_msg_fn      (req_fn),
      .muldivreq_msg_mask    (req_mask),
      .muldivreq_msg_a       (req_a),
      .muldivreq_msg_b       (req_b),
      .muldivreq_val         (req_val),
      .muldivreq_rdy         (req_rdy),
      .muldivresp_msg_result (resp_result),
      .muldivresp_val        (resp_val),
      .muldivresp_rdy        (resp_rdy)
   );

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference arithmetic for one lane, straight from the RISC-V rules.
   function automatic logic [31:0] ref_lane(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
      int  sa, sb;
      logic ovf;
      sa  = a;
      sb = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (fn)
         3'd0: return a * b;
         3'd1: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
         3'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd3: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
         3'd4: return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [VW-1:0] ref_vec(input logic [2:0] fn, input logic [3:0] mask,
                                             input logic [VW-1:0] a, input logic [VW-1:0] b);
      logic [VW-1:0] r;
      r = '0;
      for (int i = 0; i < NLANES; i++)
         if (mask[i]) r[i*WIDTH +: WIDTH] = ref_lane(fn, a[i*WIDTH +: WIDTH], b[i*WIDTH +: WIDTH]);
      return r;
   endfunction

   function automatic logic [VW-1:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   // One full transaction: wait for rdy, accept, check latency, hold the
   // response for `hold` cycles, then take it and check the return to IDLE.
   task automatic do_req(input string tag, input logic [2:0] fn, input logic [3:0] mask,
                         input logic [VW-1:0] a, input logic [VW-1:0] b, input int hold);
      logic [VW-1:0] exp;
      int k;
      exp = ref_vec(fn, mask, a, b);
      @(negedge clk);
      req_fn = fn; req_mask = mask; req_a = a; req_b = b; req_val = 1'b1; resp_rdy = 1'b0;
      k = 0;
      while (!req_rdy && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!req_rdy) begin
         check({tag, "_rdy_timeout"}, 1'b0, 1'b1);
         req_val = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      // Scramble inputs after the accept edge; they must be ignored.
      req_val = 1'b0;
      req_fn = 3'($urandom); req_mask = 4'($urandom);
      req_a = {$urandom, $urandom, $urandom, $urandom};
      req_b = {$urandom, $urandom, $urandom, $urandom};
      k = 0;
      while (k < 40) begin
         @(posedge clk);
         #1;
         k++;
         if (resp_val) break;
      end
      // resp_val first seen right after edge E+WIDTH.
      check({tag, "_latency"}, VW'(k), VW'(WIDTH));
      if (!resp_val) return;
      check({tag, "_result"}, resp_result, exp);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, "_hold_result"}, resp_result, exp);
         check({tag, "_hold_rdy_val"}, {req_rdy, resp_val}, 2'b01);
      end
      @(negedge clk);
      resp_rdy = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_idle_after_ack"}, {req_rdy, resp_val}, 2'b10);
      resp_rdy = 1'b0;
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [VW-1:0] ra, rb;
      int            k;

      reset = 1'b1; req_val = 1'b1; resp_rdy = 1'b0;
      req_fn = 3'd0; req_mask = 4'hF; req_a = '0; req_b = '0;

      // 1: reset held 3 cycles with req_val high.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("reset_rdy_val", {req_rdy, resp_val}, 2'b00);
      end
      check("reset_result", resp_result, '0);
      reset = 1'b0; req_val = 1'b0;
      #1;
      check("post_reset_rdy", req_rdy, 1'b1);

      // 2: MUL with latency check.
      do_req("mul", 3'd0, 4'hF,
             pack4(32'd7, 32'hFFFF_FFFD, 32'h0000_FFFF, 32'h8000_0000),
             pack4(32'd6, 32'd5, 32'h0001_0001, 32'd2), 0);
      check("mul_spec_vals",
            ref_vec(3'd0, 4'hF, pack4(32'd7, 32'hFFFF_FFFD, 32'h0000_FFFF, 32'h8000_0000),
                    pack4(32'd6, 32'd5, 32'h0001_0001, 32'd2)),
            pack4(32'd42, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 32'd0));

      // 3: signed and unsigned divide/remainder.
      ra = {4{32'hFFFF_FFF9}};
      rb = {4{32'd2}};
      do_req("div", 3'd1, 4'hF, ra, rb, 0);
      do_req("rem", 3'd3, 4'hF, ra, rb, 0);
      do_req("divu", 3'd2, 4'hF, ra, rb, 0);
      do_req("remu", 3'd4, 4'hF, ra, rb, 0);

      // 4: overflow and divide-by-zero corners.
      ra = pack4(32'h8000_0000, 32'd5, 32'hFFFF_FFFB, 32'd0);
      rb = pack4(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
      do_req("div_corner", 3'd1, 4'hF, ra, rb, 0);
      do_req("rem_corner", 3'd3, 4'hF, ra, rb, 0);
      do_req("divu_corner", 3'd2, 4'hF, ra, rb, 0);
      do_req("remu_corner", 3'd4, 4'hF, ra, rb, 0);

      // 5: backpressure with partial mask, then a normal request.
      do_req("bp_mask", 3'd1, 4'b0101, pack4(32'd100, 32'd50, 32'hFFFF_FF9C, 32'd9),
             pack4(32'd7, 32'd3, 32'd7, 32'd2), 10);
      do_req("after_bp", 3'd0, 4'hF, pack4(32'd11, 32'd12, 32'd13, 32'd14),
             pack4(32'd3, 32'd3, 32'd3, 32'd3), 0);
      do_req("reserved_fn", 3'd6, 4'hF, {4{32'd9}}, {4{32'd3}}, 0);
      do_req("mask_none", 3'd0, 4'h0, {4{32'd9}}, {4{32'd3}}, 0);

      // 6: reset mid-CALC when the counter reads 15 (16 edges after accept).
      @(negedge clk);
      req_fn = 3'd0; req_mask = 4'hF; req_a = {4{32'd5}}; req_b = {4{32'd5}}; req_val = 1'b1;
      @(posedge clk);
      #1;
      req_val = 1'b0;
      repeat (16) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midcalc_reset_idle", {req_rdy, resp_val}, 2'b10);
      k = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (resp_val) k++;
      end
      check("midcalc_no_resp", VW'(k), '0);
      do_req("mul_3x4", 3'd0, 4'hF, {4{32'd3}}, {4{32'd4}}, 0);

      // Randomized requests against the reference model.
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < NLANES; i++) begin
            ra[i*WIDTH +: WIDTH] = rand_operand();
            rb[i*WIDTH +: WIDTH] = rand_operand();
         end
         do_req("rand", 3'($urandom_range(0, 7)), 4'($urandom), ra, rb,
                int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
